axi4_lite_xbar_1xn: RTL and testbench

//  Parametrised AXI4-Lite 1-master-to-N-slave router; successor to the single master/slave top.

---
 rtl/axi4_lite_pkg.sv | 29 ++
 rtl/axi4_lite_addr_decode.sv | 26 ++
 rtl/axi4_lite_xbar_1xn.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi4_lite_xbar_1xn.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - response codes, FSM state types and index sizing for the AXI4-Lite crossbar
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_RESP,
        W_BACK
    } wr_state_t;

    // A single slave still needs a one-bit index so the select logic stays uniform.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// rtl/axi4_lite_addr_decode.sv - maps an address onto one of NUM_SLAVES equal windows
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NUM_SLAVES    = 4,
    parameter int                       WINDOW_BITS   = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       IDX_WIDTH     = idx_width(NUM_SLAVES)
) (
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     hit,
    output logic [IDX_WIDTH-1:0]     idx
);

    logic [ADDRESS_WIDTH-1:0] off;
    logic [ADDRESS_WIDTH-1:0] slot;

    always_comb begin
        off  = addr - BASE_ADDR;
        slot = off >> WINDOW_BITS;
        hit  = (addr >= BASE_ADDR) && (slot < ADDRESS_WIDTH'(NUM_SLAVES));
        idx  = slot[IDX_WIDTH-1:0];
    end

endmodule

// File: rtl/axi4_lite_xbar_1xn.sv
// rtl/axi4_lite_xbar_1xn.sv - AXI4-Lite 1-master to N-slave router with DECERR for unmapped addresses
module axi4_lite_xbar_1xn
    import axi4_lite_pkg::*;
#(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NUM_SLAVES    = 4,
    parameter int                       WINDOW_BITS   = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ADDRESS_WIDTH-1:0]         S_AWADDR,
    input  logic                             S_AWVALID,
    output logic                             S_AWREADY,
    input  logic [DATA_WIDTH-1:0]            S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          S_WSTRB,
    input  logic                             S_WVALID,
    output logic                             S_WREADY,
    output logic [1:0]                       S_BRESP,
    output logic                             S_BVALID,
    input  logic                             S_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]         S_ARADDR,
    input  logic                             S_ARVALID,
    output logic                             S_ARREADY,
    output logic [DATA_WIDTH-1:0]            S_RDATA,
    output logic [1:0]                       S_RRESP,
    output logic                             S_RVALID,
    input  logic                             S_RREADY,
    output logic [ADDRESS_WIDTH-1:0]         M_AWADDR,
    output logic [ADDRESS_WIDTH-1:0]         M_ARADDR,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_WSTRB,
    output logic [NUM_SLAVES-1:0]            M_AWVALID,
    output logic [NUM_SLAVES-1:0]            M_WVALID,
    output logic [NUM_SLAVES-1:0]            M_ARVALID,
    output logic [NUM_SLAVES-1:0]            M_BREADY,
    output logic [NUM_SLAVES-1:0]            M_RREADY,
    input  logic [NUM_SLAVES-1:0]            M_AWREADY,
    input  logic [NUM_SLAVES-1:0]            M_WREADY,
    input  logic [NUM_SLAVES-1:0]            M_ARREADY,
    input  logic [NUM_SLAVES-1:0]            M_BVALID,
    input  logic [NUM_SLAVES-1:0]            M_RVALID,
    input  logic [NUM_SLAVES*2-1:0]          M_BRESP,
    input  logic [NUM_SLAVES*2-1:0]          M_RRESP,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] M_RDATA
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = idx_width(NUM_SLAVES);

    function automatic logic [NUM_SLAVES-1:0] sel(input logic [IDX_WIDTH-1:0] i);
        return NUM_SLAVES'(1) << i;
    endfunction

    // Read path state
    rd_state_t                rd_state;
    logic                     ar_ready_q;
    logic [ADDRESS_WIDTH-1:0] ar_addr_q;
    logic [IDX_WIDTH-1:0]     rd_idx_q;
    logic [NUM_SLAVES-1:0]    m_arvalid_q;
    logic [NUM_SLAVES-1:0]    m_rready_q;
    logic                     r_valid_q;
    logic [DATA_WIDTH-1:0]    r_data_q;
    logic [1:0]               r_resp_q;
    logic                     ar_hit;
    logic [IDX_WIDTH-1:0]     ar_idx;

    // Write path state
    wr_state_t                wr_state;
    logic                     aw_held;
    logic                     w_held;
    logic                     aw_ready_q;
    logic                     w_ready_q;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;
    logic [NUM_SLAVES-1:0]    m_awvalid_q;
    logic [NUM_SLAVES-1:0]    m_wvalid_q;
    logic [NUM_SLAVES-1:0]    m_bready_q;
    logic                     b_valid_q;
    logic [1:0]               b_resp_q;
    logic                     aw_hit;
    logic [IDX_WIDTH-1:0]     aw_idx;

    axi4_lite_addr_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .WINDOW_BITS  (WINDOW_BITS),
        .BASE_ADDR    (BASE_ADDR),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_ar_decode (
        .addr(S_ARADDR),
        .hit (ar_hit),
        .idx (ar_idx)
    );

    // Write decode runs on the latched address because AW and W may arrive in either order.
    axi4_lite_addr_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .WINDOW_BITS  (WINDOW_BITS),
        .BASE_ADDR    (BASE_ADDR),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_aw_decode (
        .addr(aw_addr_q),
        .hit (aw_hit),
        .idx (aw_idx)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state    <= R_IDLE;
            ar_ready_q  <= 1'b0;
            ar_addr_q   <= '0;
            rd_idx_q    <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_ready_q && S_ARVALID) begin
                        ar_ready_q <= 1'b0;
                        ar_addr_q  <= S_ARADDR;
                        rd_idx_q   <= ar_idx;
                        if (ar_hit) begin
                            m_arvalid_q <= sel(ar_idx);
                            rd_state    <= R_ADDR;
                        end else begin
                            r_data_q  <= '0;
                            r_resp_q  <= DECERR;
                            r_valid_q <= 1'b1;
                            rd_state  <= R_RESP;
                        end
                    end
                end
                R_ADDR: begin
                    if (M_ARREADY[rd_idx_q]) begin
                        m_arvalid_q <= '0;
                        m_rready_q  <= sel(rd_idx_q);
                        rd_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (M_RVALID[rd_idx_q]) begin
                        m_rready_q <= '0;
                        r_data_q   <= M_RDATA[int'(rd_idx_q)*DATA_WIDTH +: DATA_WIDTH];
                        r_resp_q   <= M_RRESP[2*int'(rd_idx_q) +: 2];
                        r_valid_q  <= 1'b1;
                        rd_state   <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (S_RREADY) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state   <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state    <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_ready_q && S_AWVALID) begin
                        aw_held    <= 1'b1;
                        aw_addr_q  <= S_AWADDR;
                        aw_ready_q <= 1'b0;
                    end else begin
                        aw_ready_q <= !aw_held;
                    end
                    if (w_ready_q && S_WVALID) begin
                        w_held    <= 1'b1;
                        w_data_q  <= S_WDATA;
                        w_strb_q  <= S_WSTRB;
                        w_ready_q <= 1'b0;
                    end else begin
                        w_ready_q <= !w_held;
                    end
                    if (aw_held && w_held) begin
                        if (aw_hit) begin
                            m_awvalid_q <= sel(aw_idx);
                            m_wvalid_q  <= sel(aw_idx);
                            wr_state    <= W_ISSUE;
                        end else begin
                            b_resp_q  <= DECERR;
                            b_valid_q <= 1'b1;
                            wr_state  <= W_BACK;
                        end
                    end
                end
                W_ISSUE: begin
                    if (M_AWREADY[aw_idx]) m_awvalid_q <= '0;
                    if (M_WREADY[aw_idx])  m_wvalid_q  <= '0;
                    if ((!(|m_awvalid_q) || M_AWREADY[aw_idx]) &&
                        (!(|m_wvalid_q)  || M_WREADY[aw_idx])) begin
                        m_bready_q <= sel(aw_idx);
                        wr_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (M_BVALID[aw_idx]) begin
                        m_bready_q <= '0;
                        b_resp_q   <= M_BRESP[2*int'(aw_idx) +: 2];
                        b_valid_q  <= 1'b1;
                        wr_state   <= W_BACK;
                    end
                end
                W_BACK: begin
                    if (S_BREADY) begin
                        b_valid_q  <= 1'b0;
                        aw_held    <= 1'b0;
                        w_held     <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state   <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign S_ARREADY = ar_ready_q;
    assign S_RVALID  = r_valid_q;
    assign S_RDATA   = r_data_q;
    assign S_RRESP   = r_resp_q;
    assign M_ARADDR  = ar_addr_q;
    assign M_ARVALID = m_arvalid_q;
    assign M_RREADY  = m_rready_q;

    assign S_AWREADY = aw_ready_q;
    assign S_WREADY  = w_ready_q;
    assign S_BVALID  = b_valid_q;
    assign S_BRESP   = b_resp_q;
    assign M_AWADDR  = aw_addr_q;
    assign M_WDATA   = w_data_q;
    assign M_WSTRB   = w_strb_q;
    assign M_AWVALID = m_awvalid_q;
    assign M_WVALID  = m_wvalid_q;
    assign M_BREADY  = m_bready_q;

endmodule

// File: tb/tb_axi4_lite_xbar_1xn.sv
// tb/tb_axi4_lite_xbar_1xn.sv - scoreboard bench with random slaves and a word-addressed reference memory
module tb_axi4_lite_xbar_1xn;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          NS   = 4;
    localparam int          WB   = 12;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [AW-1:0] S_AWADDR, S_ARADDR, M_AWADDR, M_ARADDR;
    logic S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [DW-1:0] S_WDATA, S_RDATA, M_WDATA;
    logic [DW/8-1:0] S_WSTRB, M_WSTRB;
    logic [1:0] S_BRESP, S_RRESP;
    logic [NS-1:0] M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY;
    logic [NS-1:0] M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID;
    logic [NS*2-1:0] M_BRESP, M_RRESP;
    logic [NS*DW-1:0] M_RDATA;

    axi4_lite_xbar_1xn #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SLAVES(NS), .WINDOW_BITS(WB), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M_AWADDR(M_AWADDR), .M_ARADDR(M_ARADDR), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_AWVALID(M_AWVALID), .M_WVALID(M_WVALID), .M_ARVALID(M_ARVALID),
        .M_BREADY(M_BREADY), .M_RREADY(M_RREADY),
        .M_AWREADY(M_AWREADY), .M_WREADY(M_WREADY), .M_ARREADY(M_ARREADY),
        .M_BVALID(M_BVALID), .M_RVALID(M_RVALID),
        .M_BRESP(M_BRESP), .M_RRESP(M_RRESP), .M_RDATA(M_RDATA)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    always @(negedge ACLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: windows of 2^WB bytes from BASE, one flat word memory
    logic [31:0] ref_mem [int unsigned];
    logic [33:0] exp_r [$];
    logic [1:0]  exp_b [$];
    int rd_issued = 0, r_done = 0, wr_issued = 0, b_done = 0;

    function automatic int slave_of(input logic [31:0] a);
        int unsigned slot;
        if (a < BASE) return -1;
        slot = (a - BASE) / (32'd1 << WB);
        return (slot < NS) ? int'(slot) : -1;
    endfunction

    function automatic logic [1:0] slave_resp(input int k, input logic [31:0] a);
        return (k == 3 && a[8]) ? SLVERR : OKAY;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    // Slave behavioural models, each with its own storage keyed by {slave, word}
    logic [31:0] smem [longint];
    bit aw_got [NS], w_got [NS], ar_got [NS], b_busy [NS], r_busy [NS];
    logic [31:0] aw_a [NS], w_d [NS], r_d [NS];
    logic [3:0]  w_s [NS];
    logic [1:0]  b_rsp [NS], r_rsp [NS];
    int b_dly [NS], r_dly [NS], aw_stall [NS], aw_hs_cnt [NS];
    bit zero_wait = 1'b1;
    int r_fixed_dly = -1;

    function automatic longint skey(input int k, input logic [31:0] a);
        return (longint'(k) << 32) | longint'(a >> 2);
    endfunction

    function automatic logic [31:0] smem_rd(input int k, input logic [31:0] a);
        return smem.exists(skey(k, a)) ? smem[skey(k, a)] : 32'h0;
    endfunction

    initial begin
        for (int k = 0; k < NS; k++) begin aw_stall[k] = 0; aw_hs_cnt[k] = 0; end
        M_AWREADY = '0; M_WREADY = '0; M_ARREADY = '0; M_BVALID = '0; M_RVALID = '0;
        M_BRESP = '0; M_RRESP = '0; M_RDATA = '0;
        forever begin
            @(posedge ACLK);
            for (int k = 0; k < NS; k++) begin
                if (ARESET) begin
                    aw_got[k] = 0; w_got[k] = 0; ar_got[k] = 0; b_busy[k] = 0; r_busy[k] = 0;
                end else begin
                    if (M_AWVALID[k] && M_AWREADY[k]) begin aw_got[k] = 1; aw_a[k] = M_AWADDR; aw_hs_cnt[k]++; end
                    if (M_WVALID[k] && M_WREADY[k]) begin w_got[k] = 1; w_d[k] = M_WDATA; w_s[k] = M_WSTRB; end
                    if (M_BVALID[k] && M_BREADY[k]) b_busy[k] = 0;
                    if (M_ARVALID[k] && M_ARREADY[k]) begin ar_got[k] = 1; r_d[k] = M_ARADDR; end
                    if (M_RVALID[k] && M_RREADY[k]) r_busy[k] = 0;
                    if (aw_got[k] && w_got[k] && !b_busy[k]) begin
                        smem[skey(k, aw_a[k])] = merge(smem_rd(k, aw_a[k]), w_d[k], w_s[k]);
                        b_rsp[k] = slave_resp(k, aw_a[k]);
                        b_dly[k] = zero_wait ? 0 : int'($urandom_range(0, 3));
                        b_busy[k] = 1; aw_got[k] = 0; w_got[k] = 0;
                    end
                    if (ar_got[k] && !r_busy[k]) begin
                        r_rsp[k] = slave_resp(k, r_d[k]);
                        r_d[k] = smem_rd(k, r_d[k]);
                        r_dly[k] = (r_fixed_dly >= 0) ? r_fixed_dly : (zero_wait ? 0 : int'($urandom_range(0, 3)));
                        r_busy[k] = 1; ar_got[k] = 0;
                    end
                end
            end
            @(negedge ACLK);
            for (int k = 0; k < NS; k++) begin
                M_AWREADY[k] = !aw_got[k] && (zero_wait || $urandom_range(0, 1) == 1);
                if (M_AWVALID[k] && aw_stall[k] > 0) begin aw_stall[k]--; M_AWREADY[k] = 1'b0; end
                M_WREADY[k]  = !w_got[k] && (zero_wait || $urandom_range(0, 1) == 1);
                M_ARREADY[k] = !ar_got[k] && (zero_wait || $urandom_range(0, 1) == 1);
                M_BVALID[k] = 1'b0;
                if (b_busy[k]) begin if (b_dly[k] > 0) b_dly[k]--; else M_BVALID[k] = 1'b1; end
                M_RVALID[k] = 1'b0;
                if (r_busy[k]) begin if (r_dly[k] > 0) r_dly[k]--; else M_RVALID[k] = 1'b1; end
                M_BRESP[2*k +: 2] = b_rsp[k];
                M_RRESP[2*k +: 2] = r_rsp[k];
                M_RDATA[k*DW +: DW] = r_d[k];
            end
        end
    end

    // Upstream response-channel backpressure
    bit ready_always = 1'b1;
    int rhold = 0;
    initial begin
        S_RREADY = 1'b0; S_BREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            if (S_RVALID && rhold > 0) begin S_RREADY = 1'b0; rhold--; end
            else S_RREADY = ready_always || $urandom_range(0, 3) != 0;
            S_BREADY = ready_always || $urandom_range(0, 3) != 0;
        end
    end

    // Monitor: pops the scoreboard at each upstream response handshake and checks routing
    logic [NS-1:0] aw_seen = '0, ar_seen = '0;
    int rise_cyc = 0, r_stall_cnt = 0;
    bit r_stalled = 0, r_prev = 0;
    logic [33:0] r_held, e_r;
    logic [1:0] e_b;
    logic [63:0] route;
    initial forever begin
        @(posedge ACLK);
        if (ARESET) begin
            r_stalled = 0; r_prev = 0;
        end else begin
            if (r_stalled) begin
                check("rvalid_held", S_RVALID, 1);
                check("rdata_stable", {S_RRESP, S_RDATA}, r_held);
            end
            if (S_RVALID && !r_prev) rise_cyc = cyc;
            if (S_RVALID && !S_RREADY) r_stall_cnt++;
            r_stalled = S_RVALID && !S_RREADY;
            r_held = {S_RRESP, S_RDATA};
            r_prev = S_RVALID && !S_RREADY;
            if (S_RVALID && S_RREADY) begin
                check("r_expected", exp_r.size() > 0, 1);
                if (exp_r.size() > 0) begin
                    e_r = exp_r.pop_front();
                    check("rdata", S_RDATA, e_r[31:0]);
                    check("rresp", S_RRESP, e_r[33:32]);
                end
                r_done++;
            end
            if (S_BVALID && S_BREADY) begin
                check("b_expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    e_b = exp_b.pop_front();
                    check("bresp", S_BRESP, e_b);
                end
                b_done++;
            end
            aw_seen |= M_AWVALID;
            ar_seen |= M_ARVALID;
            if (|M_AWVALID) begin
                route = (slave_of(M_AWADDR) < 0) ? 64'h0 : (64'h1 << slave_of(M_AWADDR));
                check("aw_route", M_AWVALID, route);
            end
            if (|M_ARVALID) begin
                route = (slave_of(M_ARADDR) < 0) ? 64'h0 : (64'h1 << slave_of(M_ARADDR));
                check("ar_route", M_ARVALID, route);
            end
        end
    end

    task automatic do_read(input logic [31:0] a, output int hs_cyc);
        int id, k;
        k = slave_of(a);
        if (k < 0) exp_r.push_back({DECERR, 32'h0});
        else exp_r.push_back({slave_resp(k, a), ref_rd(a)});
        rd_issued++; id = rd_issued; hs_cyc = -1;
        @(negedge ACLK);
        S_ARADDR = a; S_ARVALID = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(posedge ACLK);
            if (S_ARREADY) begin hs_cyc = cyc; break; end
        end
        @(negedge ACLK);
        S_ARVALID = 1'b0;
        for (int w = 0; w < 400 && r_done < id; w++) @(negedge ACLK);
        check("rd_complete", r_done >= id, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        int id, k;
        k = slave_of(a);
        if (k < 0) exp_b.push_back(DECERR);
        else begin
            exp_b.push_back(slave_resp(k, a));
            ref_mem[a >> 2] = merge(ref_rd(a), d, s);
        end
        wr_issued++; id = wr_issued;
        @(negedge ACLK);
        fork
            begin
                repeat (aw_dly) @(negedge ACLK);
                S_AWADDR = a; S_AWVALID = 1'b1;
                for (int w = 0; w < 200; w++) begin @(posedge ACLK); if (S_AWREADY) break; end
                @(negedge ACLK);
                S_AWVALID = 1'b0;
            end
            begin
                repeat (w_dly) @(negedge ACLK);
                S_WDATA = d; S_WSTRB = s; S_WVALID = 1'b1;
                for (int w = 0; w < 200; w++) begin @(posedge ACLK); if (S_WREADY) break; end
                @(negedge ACLK);
                S_WVALID = 1'b0;
            end
        join
        for (int w = 0; w < 400 && b_done < id; w++) @(negedge ACLK);
        check("wr_complete", b_done >= id, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int hs, cnt0, st0;
    logic [31:0] wa, ra, wd;
    initial begin
        ARESET = 1'b1;
        S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0;
        S_ARADDR = '0; S_ARVALID = 0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        check("rst_s_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
        check("rst_s_valid", {S_BVALID, S_RVALID}, 2'b00);
        check("rst_m_valid", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, '0);
        check("rst_data", {S_RDATA, S_RRESP, S_BRESP}, '0);
        @(negedge ACLK);
        check("idle_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

        // Directed cases on zero-wait slaves
        aw_seen = '0;
        do_write(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("t1_awvalid_onehot", aw_seen, 4'b0010);
        check("t1_slave1_mem", smem_rd(1, 32'h0000_1004), 32'hDEAD_BEEF);

        do_read(32'h0000_1004, hs);
        check("t2_latency", rise_cyc - hs, 3);

        ar_seen = '0;
        do_read(32'h0000_4000, hs);
        check("t3_no_arvalid", ar_seen, '0);

        cnt0 = aw_hs_cnt[2];
        aw_stall[2] = 5;
        do_write(32'h0000_2010, 32'h1234_5678, 4'hF, 2, 0);
        check("t4_single_write", aw_hs_cnt[2] - cnt0, 1);
        check("t4_stall_used", aw_stall[2], 0);
        do_read(32'h0000_2010, hs);

        do_write(32'h0000_0008, 32'hA5A5_5A5A, 4'hF, 0, 0);
        st0 = r_stall_cnt;
        rhold = 4;
        fork
            do_read(32'h0000_0008, hs);
            do_write(32'h0000_3120, 32'hCAFE_F00D, 4'h3, 0, 0);
        join
        check("t5_rready_stall", r_stall_cnt - st0 >= 4, 1);
        do_read(32'h0000_3120, hs);

        // Random mixed traffic, including unmapped windows and concurrent read/write
        zero_wait = 1'b0;
        ready_always = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wa = ($urandom_range(0, 5) << WB) | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2);
            wd = $urandom;
            do begin
                ra = ($urandom_range(0, 5) << WB) | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2);
            end while ((ra >> 2) == (wa >> 2));
            case ($urandom_range(0, 2))
                0: do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(ra, hs);
                default: fork
                    do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
                    do_read(ra, hs);
                join
            endcase
        end

        // Reset pulsed while the read waits on a slow slave's data
        zero_wait = 1'b1;
        ready_always = 1'b1;
        r_fixed_dly = 6;
        @(negedge ACLK);
        S_ARADDR = 32'h0000_1004; S_ARVALID = 1'b1;
        for (int w = 0; w < 50 && M_RREADY == '0; w++) begin
            @(negedge ACLK);
            if (!S_ARREADY) S_ARVALID = 1'b0;
        end
        S_ARVALID = 1'b0;
        check("t6_in_rdata", M_RREADY, 4'b0010);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t6_m_valid_low", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, '0);
        check("t6_s_low", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID}, '0);
        ARESET = 1'b0;
        r_fixed_dly = -1;
        @(negedge ACLK);
        do_read(32'h0000_1004, hs);
        check("t6_queue_drained", exp_r.size() + exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
